conv_wr_writeback: RTL and testbench

//  Write-request engine of the conv-layer AFU: transmit side of the QPI wr_req/wr_rsp interface.

---
 rtl/afu_pkg.sv | 23 ++
 rtl/conv_wr_writeback_if.sv | 28 ++
 rtl/wb_sync_fifo.sv | 57 +++++
 rtl/conv_wr_writeback.sv | 141 ++++++++++++++
 tb/tb_conv_wr_writeback.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/afu_pkg.sv
// Shared types and constants for the conv-layer AFU datapath.
package afu_pkg;

    localparam int CL_BYTES_LOG2 = 6;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        DONE
    } wb_state_t;

    // Occupancy at which the write buffer warns the read side to back off.
    function automatic int af_threshold(input int depth_log2, input int margin);
        return (2 ** depth_log2) - margin;
    endfunction

endpackage

// File: rtl/conv_wr_writeback_if.sv
// QPI write request / write response bundle between the write-back engine and afu_user.
interface conv_wr_writeback_if #(
    parameter int ADDR_LMT    = 58,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512
);
    logic [ADDR_LMT-1:0]    wr_req_addr;
    logic [MDATA-1:0]       wr_req_mdata;
    logic [CACHE_WIDTH-1:0] wr_req_data;
    logic                   wr_req_en;
    logic                   wr_req_almostfull;
    logic                   wr_rsp0_valid;
    logic [MDATA-1:0]       wr_rsp0_mdata;
    logic                   wr_rsp1_valid;
    logic [MDATA-1:0]       wr_rsp1_mdata;

    // Request issuer (the write-back engine).
    modport master (
        output wr_req_addr, wr_req_mdata, wr_req_data, wr_req_en,
        input  wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata
    );

    // QPI side that accepts requests and returns completions.
    modport slave (
        input  wr_req_addr, wr_req_mdata, wr_req_data, wr_req_en,
        output wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata
    );
endinterface

// File: rtl/wb_sync_fifo.sv
// Single-clock first-word-fall-through buffer for outgoing cachelines.
// Reset clears pointers and count only; the storage array is left untouched.
module wb_sync_fifo #(
    parameter int WIDTH      = 512,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // Head is read combinationally so the oldest entry is visible without a read cycle.
    assign head    = mem[rd_ptr_reg];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/conv_wr_writeback.sv
// Write-request engine: buffers IFFT output cachelines, issues them as sequential
// cacheline writes from the destination base and counts completions until done.
module conv_wr_writeback
    import afu_pkg::*;
#(
    parameter int ADDR_LMT        = 58,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int FIFO_DEPTH_LOG2 = 6,
    parameter int AF_MARGIN       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_LMT-1:0]    dest_base_addr,
    input  logic [31:0]            num_cl_out,
    input  logic                   in_valid,
    input  logic [CACHE_WIDTH-1:0] in_data,
    output logic                   fifo_almostfull,
    conv_wr_writeback_if.master    wr,
    output logic                   done,
    output logic                   overflow
);
    localparam int AF_THRESH = af_threshold(FIFO_DEPTH_LOG2, AF_MARGIN);

    wb_state_t              state_reg, state_next;
    logic [ADDR_LMT-1:0]    base_reg;
    logic [31:0]            num_reg, issued_reg, accepted_reg, acked_reg;
    logic                   done_reg, overflow_reg, af_reg;
    logic                   wr_en_reg;
    logic [ADDR_LMT-1:0]    wr_addr_reg;
    logic [MDATA-1:0]       wr_mdata_reg;
    logic [CACHE_WIDTH-1:0] wr_data_reg;

    logic                   fifo_full, fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic [CACHE_WIDTH-1:0] fifo_head;
    logic                   start_ok, push, pop, drop, ack_active, ack_sat, af_next;
    logic [31:0]            rsp_sum, ack_room, ack_inc;
    logic                   unused_rsp_tags;

    // Completion tags are not matched, only counted.
    assign unused_rsp_tags = ^{wr.wr_rsp0_mdata, wr.wr_rsp1_mdata};

    assign start_ok   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign push       = in_valid && (state_reg == RUN) && (accepted_reg < num_reg) && !fifo_full;
    // Anything arriving that cannot be stored is lost and flagged; the start cycle itself is exempt.
    assign drop       = in_valid && !push && !start_ok;
    assign pop        = (state_reg == RUN) && !fifo_empty && !wr.wr_req_almostfull
                        && (issued_reg < num_reg);
    assign ack_active = (state_reg == RUN) || (state_reg == WAIT);
    assign rsp_sum    = 32'(wr.wr_rsp0_valid) + 32'(wr.wr_rsp1_valid);
    assign ack_room   = num_reg - acked_reg;
    assign ack_sat    = ack_active && (rsp_sum > ack_room);
    assign ack_inc    = ack_sat ? ack_room : rsp_sum;
    // Evaluate the threshold on the post-edge occupancy so the flag tracks the count exactly.
    assign af_next    = (int'(fifo_count) + int'(push) - int'(pop)) >= AF_THRESH;

    wb_sync_fifo #(
        .WIDTH      (CACHE_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (in_data),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Next-state logic: a zero-length job goes straight to DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = (num_cl_out == 32'd0) ? DONE : RUN;
            RUN:        if (issued_reg == num_reg) state_next = WAIT;
            WAIT:       if (acked_reg == num_reg) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // State, job parameters, progress counters and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            num_reg      <= '0;
            issued_reg   <= '0;
            accepted_reg <= '0;
            acked_reg    <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            af_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                base_reg     <= dest_base_addr;
                num_reg      <= num_cl_out;
                issued_reg   <= '0;
                accepted_reg <= '0;
                acked_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push)       accepted_reg <= accepted_reg + 32'd1;
                if (pop)        issued_reg   <= issued_reg + 32'd1;
                if (ack_active) acked_reg    <= acked_reg + ack_inc;
                if (drop || ack_sat) overflow_reg <= 1'b1;
            end
            done_reg <= (state_next == DONE);
            af_reg   <= af_next;
        end
    end

    // Registered write request; address wraps naturally at the address width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_mdata_reg <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_en_reg <= pop;
            if (pop) begin
                wr_addr_reg  <= base_reg + ADDR_LMT'(issued_reg);
                wr_mdata_reg <= issued_reg[MDATA-1:0];
                wr_data_reg  <= fifo_head;
            end
        end
    end

    assign wr.wr_req_en     = wr_en_reg;
    assign wr.wr_req_addr   = wr_addr_reg;
    assign wr.wr_req_mdata  = wr_mdata_reg;
    assign wr.wr_req_data   = wr_data_reg;
    assign done             = done_reg;
    assign overflow         = overflow_reg;
    assign fifo_almostfull  = af_reg;
endmodule

// File: tb/tb_conv_wr_writeback.sv
// Bench for conv_wr_writeback: job table, random jobs and hand-written corner sequences.
module tb_conv_wr_writeback;

    typedef struct {
        logic [57:0]  addr;
        logic [13:0]  mdata;
        logic [511:0] data;
    } exp_t;

    typedef struct {
        logic [57:0] base;
        int          num;
        int          af_lo;
        int          af_hi;
        bit          dual;
        bit          gaps;
        int          restart_c;
        logic [57:0] exp_last;
        int          exp_writes;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [57:0]  dest_base_addr = '0;
    logic [31:0]  num_cl_out = '0;
    logic         in_valid = 1'b0;
    logic [511:0] in_data = '0;
    logic         fifo_almostfull, done, overflow;

    conv_wr_writeback_if wq ();

    conv_wr_writeback dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .dest_base_addr  (dest_base_addr),
        .num_cl_out      (num_cl_out),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .fifo_almostfull (fifo_almostfull),
        .wr              (wq),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    logic [57:0] last_addr = '0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    vec_t        vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_data(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] rand_cl();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Every issued write must match the next expected cacheline of the current job.
    always @(posedge clk) begin
        #1;
        if (wq.wr_req_en === 1'b1) begin
            writes_seen++;
            last_addr = wq.wr_req_addr;
            check("no_issue_while_qpi_af", 64'(wq.wr_req_almostfull), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h required no write", wq.wr_req_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(wq.wr_req_addr), 64'(mon_e.addr));
                check("wr_mdata", 64'(wq.wr_req_mdata), 64'(mon_e.mdata));
                check_data("wr_data", wq.wr_req_data, mon_e.data);
            end
        end
    end

    task automatic start_job(input logic [57:0] base, input int num);
        @(negedge clk);
        writes_seen    = 0;
        start          = 1'b1;
        dest_base_addr = base;
        num_cl_out     = 32'(num);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        in_valid = 1'b0;
        wq.wr_req_almostfull = 1'b0;
        wq.wr_rsp0_valid = 1'b0;
        wq.wr_rsp1_valid = 1'b0;
    endtask

    // Runs one job with a simple responder that acknowledges every observed write.
    task automatic run_job(input vec_t v);
        int fed = 0;
        int sent = 0;
        int last_rsp_c = -2;
        int got_c = -1;
        start_job(v.base, v.num);
        for (int c = 0; c < 400 && got_c < 0; c++) begin
            if (done === 1'b1) begin
                got_c = c;
            end else begin
                start = (c == v.restart_c);
                if (c == v.restart_c) begin
                    dest_base_addr = 58'h9000;
                    num_cl_out     = 32'd5;
                end
                in_valid = (fed < v.num) && (!v.gaps || $urandom_range(0, 3) != 0);
                if (in_valid) begin
                    in_data = rand_cl();
                    exp_q.push_back('{addr: v.base + 58'(fed), mdata: 14'(fed), data: in_data});
                    fed++;
                end
                wq.wr_req_almostfull = (c >= v.af_lo) && (c <= v.af_hi);
                wq.wr_rsp0_valid = 1'b0;
                wq.wr_rsp1_valid = 1'b0;
                if (v.dual && (writes_seen - sent) >= 2) begin
                    wq.wr_rsp0_valid = 1'b1;
                    wq.wr_rsp1_valid = 1'b1;
                    sent += 2;
                    last_rsp_c = c;
                end else if (!v.dual && (writes_seen - sent) >= 1) begin
                    wq.wr_rsp0_valid = 1'b1;
                    sent += 1;
                    last_rsp_c = c;
                end
                @(negedge clk);
            end
        end
        clear_inputs();
        check("job_done_reached", 64'(got_c >= 0), 64'd1);
        check("done_latency_cycles", 64'(got_c), 64'(last_rsp_c + 2));
        check("write_count", 64'(writes_seen), 64'(v.exp_writes));
        if (v.num > 0) check("last_addr", 64'(last_addr), 64'(v.exp_last));
        check("overflow_clear", 64'(overflow), 64'd0);
        repeat (3) @(negedge clk);
        check("done_held", 64'(done), 64'd1);
        $display("job base=%0h num=%0d writes=%0d done_cycle=%0d", v.base, v.num, writes_seen, got_c);
    endtask

    initial begin
        vecs[0] = '{58'h1000, 4, -1, -1, 1'b0, 1'b0, -1, 58'h1003, 4};
        vecs[1] = '{58'h2000, 8, 3, 10, 1'b0, 1'b0, -1, 58'h2007, 8};
        vecs[2] = '{58'h3000, 2, -1, -1, 1'b1, 1'b0, -1, 58'h3001, 2};
        vecs[3] = '{58'h3FFFFFFFFFFFFFE, 4, -1, -1, 1'b0, 1'b0, -1, 58'h1, 4};
        vecs[4] = '{58'h5000, 0, -1, -1, 1'b0, 1'b0, -1, 58'h0, 0};
        vecs[5] = '{58'h4000, 3, -1, -1, 1'b0, 1'b0, 1, 58'h4002, 3};
        vecs[6] = '{58'h7000, 2, -1, -1, 1'b0, 1'b0, -1, 58'h7001, 2};

        clear_inputs();
        wq.wr_rsp0_mdata = '0;
        wq.wr_rsp1_mdata = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_req_en", 64'(wq.wr_req_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_fifo_af", 64'(fifo_almostfull), 64'd0);
        check("rst_addr", 64'(wq.wr_req_addr), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Random jobs against the arithmetic model in run_job.
        for (int r = 0; r < 6; r++) begin
            vec_t rv;
            rv.base       = {26'($urandom), $urandom};
            rv.dual       = $urandom_range(0, 1);
            rv.num        = rv.dual ? 2 * $urandom_range(1, 8) : $urandom_range(1, 16);
            rv.af_lo      = $urandom_range(0, 10);
            rv.af_hi      = rv.af_lo + $urandom_range(0, 8);
            rv.gaps       = 1'b1;
            rv.restart_c  = -1;
            rv.exp_last   = rv.base + 58'(rv.num) - 58'd1;
            rv.exp_writes = rv.num;
            run_job(rv);
        end

        // Two-cycle latency from in_valid to wr_req_en.
        start_job(58'h10, 1);
        in_valid = 1'b1;
        in_data  = rand_cl();
        exp_q.push_back('{addr: 58'h10, mdata: 14'd0, data: in_data});
        @(negedge clk);
        in_valid = 1'b0;
        check("latency_e1_en_low", 64'(wq.wr_req_en), 64'd0);
        @(negedge clk);
        check("latency_e2_en_high", 64'(wq.wr_req_en), 64'd1);
        wq.wr_rsp0_valid = 1'b1;
        @(negedge clk);
        wq.wr_rsp0_valid = 1'b0;
        for (int t = 0; t < 20 && done !== 1'b1; t++) @(negedge clk);
        check("latency_job_done", 64'(done), 64'd1);

        // Buffer fills behind a stalled QPI queue; the 65th line is dropped.
        wq.wr_req_almostfull = 1'b1;
        start_job(58'h8000, 100);
        for (int k = 0; k < 65; k++) begin
            if (k == 55 || k == 56) check("fifo_af_at_count", 64'(fifo_almostfull), 64'(k >= 56));
            if (k == 64) check("overflow_before_65th", 64'(overflow), 64'd0);
            in_valid = 1'b1;
            in_data  = rand_cl();
            if (k < 64) exp_q.push_back('{addr: 58'h8000 + 58'(k), mdata: 14'(k), data: in_data});
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("overflow_after_65th", 64'(overflow), 64'd1);
        wq.wr_req_almostfull = 1'b0;
        for (int t = 0; t < 100 && writes_seen < 64; t++) @(negedge clk);
        check("full_fifo_drain_count", 64'(writes_seen), 64'd64);
        check("full_fifo_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-job after three of six writes issued.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        start_job(58'h6000, 6);
        for (int f = 0, t = 0; t < 40 && writes_seen < 3; t++) begin
            in_valid = (f < 6);
            if (in_valid) begin
                in_data = rand_cl();
                exp_q.push_back('{addr: 58'h6000 + 58'(f), mdata: 14'(f), data: in_data});
                f++;
            end
            @(negedge clk);
        end
        check("midjob_three_issued", 64'(writes_seen), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_wr_req_en", 64'(wq.wr_req_en), 64'd0);
        check("midrst_addr", 64'(wq.wr_req_addr), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_fifo_af", 64'(fifo_almostfull), 64'd0);
        exp_q.delete();
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        run_job(vecs[6]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
